// File: rtl/mmd_divider_ctrl.sv
// -----------------------------------------------------------------------------
// mmd_divider_ctrl
//
// Multi-modulus divider control stage for the fractional-N PLL. It sits
// directly behind the MASH modulator and divides clk by R = n_int + dn each
// output period.
//
// Each period begins with a one-cycle div_tick. On that same edge the divider
// samples n_int and dn and latches the resulting ratio. The modulator advances
// on div_tick, so the new dn it presents is consumed at the following tick.
//
// The effective ratio is clamped to the range [MIN_DIV, 2^(NBITS+1)-1].
// div_out is high for ceil(R/2) cycles, starting at the tick, and then low for
// floor(R/2) cycles.
//
// Optional feature: define MMD_CLAMP_FLAG_EN to add the sticky clamp_err
// output. clamp_err is set whenever a sampled ratio had to be clamped, and it
// is cleared only by rst_n.
// -----------------------------------------------------------------------------
module mmd_divider_ctrl #(
    parameter int NBITS   = 8,
    parameter int DN_BITS = 4,
    parameter int MIN_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NBITS-1:0]   n_int,
    input  logic [DN_BITS-1:0] dn,
    output logic               div_out,
    output logic               div_tick,
    output logic [NBITS:0]     ratio_cur
`ifdef MMD_CLAMP_FLAG_EN
    ,
    output logic               clamp_err
`endif
);

    // Raw sum width: one extra bit holds the carry out of n_int + dn.
    // A second extra bit is the sign, so negative sums stay representable.
    localparam int RW = NBITS + 2;

    localparam logic signed [RW-1:0] MIN_S = RW'(MIN_DIV);
    localparam logic signed [RW-1:0] MAX_S = RW'((1 << (NBITS + 1)) - 1);
    localparam logic [NBITS:0]       MIN_R = (NBITS + 1)'(MIN_DIV);
    localparam logic [NBITS:0]       MAX_R = '1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t               r_state;
    logic [NBITS:0]       r_count;
    logic [NBITS:0]       r_ratio;
    logic                 r_div_out;
    logic                 r_div_tick;

    logic signed [RW-1:0] w_n_ext;
    logic signed [RW-1:0] w_dn_ext;
    logic signed [RW-1:0] w_rraw;
    logic                 w_clamp_lo;
    logic                 w_clamp_hi;
    logic [NBITS:0]       w_ratio;
    logic [NBITS:0]       w_ratio_m1;
    logic                 w_sample_high;
    logic [NBITS:0]       w_count_dec;
    logic                 w_dec_high;
    logic                 w_sample;

    // n_int is unsigned, so it is zero-extended. dn is two's complement, so it
    // is sign-extended. Both become RW-bit signed operands.
    assign w_n_ext  = {2'b00, n_int};
    assign w_dn_ext = {{(RW - DN_BITS){dn[DN_BITS-1]}}, dn};
    assign w_rraw   = w_n_ext + w_dn_ext;

    // Clamp the raw ratio into the legal divide range.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so that no path can leave it unassigned and infer a latch.
        w_clamp_lo = 1'b0;
        w_clamp_hi = 1'b0;
        w_ratio    = w_rraw[NBITS:0];
        if (w_rraw < MIN_S) begin
            w_clamp_lo = 1'b1;
            w_ratio    = MIN_R;
        end else if (w_rraw > MAX_S) begin
            w_clamp_hi = 1'b1;
            w_ratio    = MAX_R;
        end
    end

    // The first cycle of a new period has count = R-1. div_out is registered
    // from the next count value, so each cycle's div_out reflects its own
    // count.
    assign w_ratio_m1    = w_ratio - (NBITS + 1)'(1);
    assign w_sample_high = (w_ratio_m1 >= (w_ratio >> 1));
    assign w_count_dec   = r_count - (NBITS + 1)'(1);
    assign w_dec_high    = (w_count_dec >= (r_ratio >> 1));

    // A sample (tick) happens on a run-enabled edge, either from IDLE or at
    // the end of a period.
    assign w_sample = en && ((r_state == ST_IDLE) || (r_count == '0));

    // Divider state machine: period counter, latched ratio and registered
    // outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so that every
        // register samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_ratio    <= MIN_R;
            r_div_out  <= 1'b0;
            r_div_tick <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_ratio    <= w_ratio;
                        r_count    <= w_ratio_m1;
                        r_div_tick <= 1'b1;
                        r_div_out  <= w_sample_high;
                        r_state    <= ST_RUN;
                    end else begin
                        r_count    <= '0;
                        r_div_tick <= 1'b0;
                        r_div_out  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (r_count != '0) begin
                        r_count    <= w_count_dec;
                        r_div_tick <= 1'b0;
                        r_div_out  <= w_dec_high;
                    end else if (en) begin
                        // Back-to-back period: resample using the inputs
                        // presented in this cycle.
                        r_ratio    <= w_ratio;
                        r_count    <= w_ratio_m1;
                        r_div_tick <= 1'b1;
                        r_div_out  <= w_sample_high;
                    end else begin
                        // The period has fully completed, so stopping here
                        // never truncates a period.
                        r_state    <= ST_IDLE;
                        r_div_tick <= 1'b0;
                        r_div_out  <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_count    <= '0;
                    r_div_tick <= 1'b0;
                    r_div_out  <= 1'b0;
                end
            endcase
        end
    end

    assign div_out   = r_div_out;
    assign div_tick  = r_div_tick;
    assign ratio_cur = r_ratio;

`ifdef MMD_CLAMP_FLAG_EN
    logic r_clamp_err;

    // Sticky flag: set by any sample whose raw ratio was clamped, in either
    // direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clamp_err <= 1'b0;
        end else if (w_sample && (w_clamp_lo || w_clamp_hi)) begin
            r_clamp_err <= 1'b1;
        end
    end

    assign clamp_err = r_clamp_err;
`endif

endmodule
